// File: rtl/seven_segment_pkg.sv
// Shared constants, buffer type and hex decode for the seven-segment controller.
package seven_segment_pkg;

  localparam logic [6:0] SEG_OFF   = 7'h7F;
  localparam logic [7:0] ANODE_OFF = 8'hFF;

  // Low-asserted segment patterns, bit 6 = A ... bit 0 = G.
  localparam logic [6:0] SEG_HEX_0 = 7'b0000001;
  localparam logic [6:0] SEG_HEX_1 = 7'b1001111;
  localparam logic [6:0] SEG_HEX_2 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_3 = 7'b0000110;
  localparam logic [6:0] SEG_HEX_4 = 7'b1001100;
  localparam logic [6:0] SEG_HEX_5 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_6 = 7'b0100000;
  localparam logic [6:0] SEG_HEX_7 = 7'b0001111;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0000100;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b1100000;
  localparam logic [6:0] SEG_HEX_C = 7'b0110001;
  localparam logic [6:0] SEG_HEX_D = 7'b1000010;
  localparam logic [6:0] SEG_HEX_E = 7'b0110000;
  localparam logic [6:0] SEG_HEX_F = 7'b0111000;

  // One complete displayable value: nibbles plus per-digit blank and dp masks.
  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  blank;
    logic [7:0]  dp;
  } disp_buf_t;

  localparam disp_buf_t DISP_RESET = '{data: 32'h0, blank: 8'hFF, dp: 8'h00};

  function automatic logic [6:0] hex_to_segments(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = SEG_HEX_0;
      4'h1:    seg = SEG_HEX_1;
      4'h2:    seg = SEG_HEX_2;
      4'h3:    seg = SEG_HEX_3;
      4'h4:    seg = SEG_HEX_4;
      4'h5:    seg = SEG_HEX_5;
      4'h6:    seg = SEG_HEX_6;
      4'h7:    seg = SEG_HEX_7;
      4'h8:    seg = SEG_HEX_8;
      4'h9:    seg = SEG_HEX_9;
      4'hA:    seg = SEG_HEX_A;
      4'hB:    seg = SEG_HEX_B;
      4'hC:    seg = SEG_HEX_C;
      4'hD:    seg = SEG_HEX_D;
      4'hE:    seg = SEG_HEX_E;
      default: seg = SEG_HEX_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_segment_decode.sv
// Combinational nibble to low-asserted seven-segment pattern.
module seven_segment_decode
  import seven_segment_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  // Pure table lookup; blanking is applied by the caller.
  always_comb begin
    segments = hex_to_segments(nibble);
  end

endmodule

// File: rtl/seven_segment_controller.sv
// Eight-digit multiplexed seven-segment driver with frame-aligned double buffering.
module seven_segment_controller
  import seven_segment_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY = 100_000_000,
  parameter int unsigned REFRESH_RATE  = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic [7:0]  blank_in,
  input  logic [7:0]  dp_in,
  input  logic        load,
  output logic        pending,
  output logic        frame_done,
  output logic [6:0]  segments,
  output logic        dp,
  output logic [7:0]  anode
);

  localparam int unsigned DIGIT_CLOCKS = CLK_FREQUENCY / REFRESH_RATE / 8;
  localparam int unsigned TICK_W = (DIGIT_CLOCKS > 1) ? $clog2(DIGIT_CLOCKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIGIT_CLOCKS - 1);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [2:0]        digit_q, digit_d;
  logic              started_q;
  logic              pending_d;
  disp_buf_t         pend_q, pend_d, act_q, act_d, load_buf;
  logic              slot_end, wrap, commit, out_upd;
  logic [3:0]        nibble;
  logic [6:0]        dec_seg;

  // Next-state for counters and buffers. The output registers are fed from the
  // next-state view so that a commit (including a bypassed load) is visible on
  // digit 0 from the very edge that starts the frame.
  always_comb begin
    load_buf.data  = data_in;
    load_buf.blank = blank_in;
    load_buf.dp    = dp_in;

    slot_end = started_q && (tick_q == TICK_LAST);
    wrap     = slot_end && (digit_q == 3'd7);
    commit   = wrap && (pending || load);
    // started_q low marks the first edge after reset: present digit 0 without counting.
    out_upd  = !started_q || slot_end;

    tick_d = tick_q;
    if (started_q) begin
      tick_d = slot_end ? '0 : tick_q + 1'b1;
    end
    digit_d = slot_end ? digit_q + 3'd1 : digit_q;

    pend_d = load ? load_buf : pend_q;

    act_d = act_q;
    if (commit) begin
      act_d = load ? load_buf : pend_q;
    end

    pending_d = pending;
    if (load) begin
      pending_d = 1'b1;
    end
    if (commit) begin
      pending_d = 1'b0;
    end

    nibble = act_d.data[4*digit_d +: 4];
  end

  seven_segment_decode u_decode (
    .nibble   (nibble),
    .segments (dec_seg)
  );

  // Scan counters and double-buffer state.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q     <= '0;
      digit_q    <= 3'd0;
      started_q  <= 1'b0;
      pending    <= 1'b0;
      pend_q     <= DISP_RESET;
      act_q      <= DISP_RESET;
      frame_done <= 1'b0;
    end else begin
      tick_q     <= tick_d;
      digit_q    <= digit_d;
      started_q  <= 1'b1;
      pending    <= pending_d;
      pend_q     <= pend_d;
      act_q      <= act_d;
      frame_done <= wrap;
    end
  end

  // Display pins, refreshed only when the selected digit changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      anode    <= ANODE_OFF;
      segments <= SEG_OFF;
      dp       <= 1'b1;
    end else if (out_upd) begin
      anode    <= ~(8'b1 << digit_d);
      segments <= act_d.blank[digit_d] ? SEG_OFF : dec_seg;
      dp       <= ~act_d.dp[digit_d];
    end
  end

endmodule

// File: tb/tb_seven_segment_controller.sv
// Directed bench for seven_segment_controller at DIGIT_CLOCKS = 10.
module tb_seven_segment_controller;

  localparam int DC    = 10;
  localparam int FRAME = 8 * DC;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic [7:0]  blank_in;
  logic [7:0]  dp_in;
  logic        load;
  logic        pending;
  logic        frame_done;
  logic [6:0]  segments;
  logic        dp;
  logic [7:0]  anode;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  blank;
    logic [7:0]  dp;
  } exp_t;

  exp_t exp_q[$];

  seven_segment_controller #(
    .CLK_FREQUENCY (1_600),
    .REFRESH_RATE  (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .blank_in   (blank_in),
    .dp_in      (dp_in),
    .load       (load),
    .pending    (pending),
    .frame_done (frame_done),
    .segments   (segments),
    .dp         (dp),
    .anode      (anode)
  );

  always #5 clk = ~clk;

  // Independent copy of the hex segment table.
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h01;  4'h1: s = 7'h4F;  4'h2: s = 7'h12;  4'h3: s = 7'h06;
      4'h4: s = 7'h4C;  4'h5: s = 7'h24;  4'h6: s = 7'h20;  4'h7: s = 7'h0F;
      4'h8: s = 7'h00;  4'h9: s = 7'h04;  4'hA: s = 7'h08;  4'hB: s = 7'h60;
      4'hC: s = 7'h31;  4'hD: s = 7'h42;  4'hE: s = 7'h30;  default: s = 7'h38;
    endcase
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, want);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] b, input logic [7:0] p);
    data_in  = d;
    blank_in = b;
    dp_in    = p;
    load     = 1'b1;
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [7:0] b, input logic [7:0] p);
    exp_t e;
    e.data  = d;
    e.blank = b;
    e.dp    = p;
    exp_q.push_back(e);
  endtask

  // Advance to the negedge that carries a frame_done pulse, within a budget.
  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * FRAME + 10; i++) begin
      step();
      load = 1'b0;
      if (frame_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("frame_done_timeout", 32'(seen), 32'd1);
  endtask

  // Starting at the first cycle of digit 0, check all 80 cycles of one frame
  // against the next scoreboard entry.
  task automatic check_frame(input bit fd_first);
    exp_t        e;
    logic [31:0] seen_val;
    logic [31:0] mask;
    logic [7:0]  want_an;
    logic [6:0]  want_seg;
    logic        want_dp;
    logic        want_fd;
    int          d;
    check("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    seen_val = '0;
    mask     = '0;
    for (int c = 0; c < FRAME; c++) begin
      if (c > 0) begin
        step();
        load = 1'b0;
      end
      d        = c / DC;
      want_an  = ~(8'b1 << d);
      want_seg = e.blank[d] ? 7'h7F : seg_of(e.data[4*d +: 4]);
      want_dp  = ~e.dp[d];
      want_fd  = (c == 0) && fd_first;
      check("anode", 32'(anode), 32'(want_an));
      check("segments", 32'(segments), 32'(want_seg));
      check("dp", 32'(dp), 32'(want_dp));
      check("frame_done", 32'(frame_done), 32'(want_fd));
      if ((c % DC) == 0 && !e.blank[d]) begin
        mask[4*d +: 4] = 4'hF;
        for (int n = 0; n < 16; n++) begin
          if (seg_of(4'(n)) == segments) seen_val[4*d +: 4] = 4'(n);
        end
      end
    end
    check("value", seen_val & mask, e.data & mask);
  endtask

  initial begin
    int pulses;
    int last_pulse;
    rst      = 1'b1;
    data_in  = '0;
    blank_in = '0;
    dp_in    = '0;
    load     = 1'b0;

    // Reset state.
    repeat (3) step();
    check("rst_anode", 32'(anode), 32'hFF);
    check("rst_segments", 32'(segments), 32'h7F);
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);

    // First edge after release selects digit 0, still blank.
    rst = 1'b0;
    step();
    check("start_anode", 32'(anode), 32'hFE);
    check("start_segments", 32'(segments), 32'h7F);

    // Reset scan: load 0x01234567.
    do_load(32'h0123_4567, 8'h00, 8'h00);
    push_exp(32'h0123_4567, 8'h00, 8'h00);
    step();
    load = 1'b0;
    check("pending_after_load", 32'(pending), 32'd1);
    wait_frame();
    check("pending_after_commit", 32'(pending), 32'd0);
    check_frame(1'b1);

    // Double buffer: two loads mid-frame, only the later one is shown.
    repeat (25) step();
    do_load(32'hDEAD_BEEF, 8'h00, 8'h00);
    step();
    load = 1'b0;
    check("pending_db1", 32'(pending), 32'd1);
    step();
    step();
    check("pending_db2", 32'(pending), 32'd1);
    do_load(32'hCAFE_F00D, 8'h00, 8'h00);
    push_exp(32'hCAFE_F00D, 8'h00, 8'h00);
    step();
    load = 1'b0;
    check("pending_db3", 32'(pending), 32'd1);
    wait_frame();
    check_frame(1'b1);

    // Load on the digit 7 -> 0 edge: bypass straight to the new frame.
    do_load(32'h89AB_CDEF, 8'h00, 8'h00);
    push_exp(32'h89AB_CDEF, 8'h00, 8'h00);
    step();
    load = 1'b0;
    check("bypass_pending", 32'(pending), 32'd0);
    check_frame(1'b1);

    // Blank and decimal point masks.
    repeat (5) step();
    do_load(32'h7654_3210, 8'hF0, 8'h05);
    push_exp(32'h7654_3210, 8'hF0, 8'h05);
    wait_frame();
    check_frame(1'b1);

    // frame_done cadence over five frames.
    pulses     = 0;
    last_pulse = -1;
    for (int i = 1; i <= 5 * FRAME; i++) begin
      step();
      if (frame_done === 1'b1) begin
        if (last_pulse >= 0) check("frame_done_spacing", 32'(i - last_pulse), 32'(FRAME));
        last_pulse = i;
        pulses++;
      end
    end
    check("frame_done_count", 32'(pulses), 32'd5);

    // Reset mid-frame during digit 3 with a load pending.
    repeat (31) step();
    do_load(32'h1111_1111, 8'h00, 8'h00);
    step();
    load = 1'b0;
    repeat (4) step();
    check("mid_anode_digit3", 32'(anode), 32'hF7);
    check("mid_pending_set", 32'(pending), 32'd1);
    rst = 1'b1;
    step();
    check("mid_rst_anode", 32'(anode), 32'hFF);
    check("mid_rst_segments", 32'(segments), 32'h7F);
    check("mid_rst_pending", 32'(pending), 32'd0);
    check("mid_rst_dp", 32'(dp), 32'd1);
    rst = 1'b0;
    push_exp(32'h0, 8'hFF, 8'h00);
    push_exp(32'h0, 8'hFF, 8'h00);
    step();
    check_frame(1'b0);
    wait_frame();
    check_frame(1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
